// File: rtl/order_book_pkg.sv
// Shared order-book frame layout.
// Used by the serializer and the parser.
package order_book_pkg;

  localparam int MSG_W = 320;
  localparam int OBJ_W = 162;
  localparam int SEQ_W = 16;

  localparam int MT_MSB  = 319;
  localparam int MT_LSB  = 312;
  localparam int OID_MSB = 249;
  localparam int OID_LSB = 218;
  localparam int SID_MSB = 184;
  localparam int SID_LSB = 153;
  localparam int QTY_MSB = 143;
  localparam int QTY_LSB = 112;
  localparam int PX_MSB  = 111;
  localparam int PX_LSB  = 48;
  localparam int SEQ_MSB = 15;
  localparam int SEQ_LSB = 0;

  localparam int O_MT_MSB  = 161;
  localparam int O_MT_LSB  = 160;
  localparam int O_SID_MSB = 159;
  localparam int O_SID_LSB = 128;
  localparam int O_OID_MSB = 127;
  localparam int O_OID_LSB = 96;
  localparam int O_QTY_MSB = 95;
  localparam int O_QTY_LSB = 64;
  localparam int O_PX_MSB  = 63;
  localparam int O_PX_LSB  = 0;

  typedef logic [MSG_W-1:0] frame_t;
  typedef logic [OBJ_W-1:0] obj_t;
  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

  function automatic frame_t pack_frame(
    input obj_t obj,
    input seq_t seq
  );
    frame_t f;
    f = '0;
    f[MT_MSB:MT_LSB] =
      {6'b0, obj[O_MT_MSB:O_MT_LSB]};
    f[OID_MSB:OID_LSB] =
      obj[O_OID_MSB:O_OID_LSB];
    f[SID_MSB:SID_LSB] =
      obj[O_SID_MSB:O_SID_LSB];
    f[QTY_MSB:QTY_LSB] =
      obj[O_QTY_MSB:O_QTY_LSB];
    f[PX_MSB:PX_LSB] =
      obj[O_PX_MSB:O_PX_LSB];
    f[SEQ_MSB:SEQ_LSB] = seq;
    return f;
  endfunction

endpackage

// File: rtl/order_book_serializer_packer.sv
// Object plus sequence number to frame.
// Purely combinational.
module order_frame_packer
  import order_book_pkg::*;
(
  input  logic [OBJ_W-1:0] obj,
  input  logic [SEQ_W-1:0] seq,
  output logic [MSG_W-1:0] frame
);

  // build the wire image from the shared layout
  always_comb begin
    frame = pack_frame(obj, seq);
  end

endmodule

// File: rtl/order_book_serializer.sv
// Order object to MSB-first beat stream.
// Stamps a frame sequence number in the tail.
module order_book_serializer
  import order_book_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [161:0]      in_object,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic [15:0]       seq_num
);

  localparam int BEATS = MSG_W / DATA_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(BEATS - 1);

  ser_state_t       state_q;
  ser_state_t       state_d;
  frame_t           shreg_q;
  frame_t           frame_new;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             shift;
  logic             bump;
  logic [15:0]      seq_nxt;

  // a frame loaded on the closing edge
  // carries the already-bumped number
  assign seq_nxt = bump
    ? seq_num + 16'd1 : seq_num;

  order_frame_packer u_packer (
    .obj   (in_object),
    .seq   (seq_nxt),
    .frame (frame_new)
  );

  assign tx_data = shreg_q[MSG_W-1 -: DATA_W];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state, handshake outputs, datapath strobes
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift    = 1'b0;
    bump     = 1'b0;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_last  = (cnt_q == LAST_CNT);
        if (tx_ready) begin
          if (tx_last) begin
            bump     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) load    = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shift register, beat counter, sequence number
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      seq_num <= '0;
    end else begin
      if (load) begin
        shreg_q <= frame_new;
        cnt_q   <= '0;
      end else if (shift) begin
        shreg_q <= shreg_q << DATA_W;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (bump) seq_num <= seq_num + 16'd1;
    end
  end

endmodule
